// File: rtl/carbon_mode_stack_if.sv
// carbon_mode_stack_if: decoder request / response handshake bundle for the mode-stack controller
interface carbon_mode_stack_if #(parameter int PC_W = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_op;
    logic [7:0]      req_tier;
    logic [PC_W-1:0] req_pc;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_ok;
    logic [7:0]      rsp_tier;
    logic [PC_W-1:0] rsp_pc;
    logic [31:0]     rsp_cause;
    modport master (
        output req_valid, req_op, req_tier, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_ok, rsp_tier, rsp_pc, rsp_cause
    );
    modport slave (
        input  req_valid, req_op, req_tier, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_ok, rsp_tier, rsp_pc, rsp_cause
    );
endinterface

// File: rtl/carbon_mode_stack_ctrl.sv
// carbon_mode_stack_ctrl: validates MODEUP/RETMD requests and owns the tier register and mode stack
module carbon_mode_stack_ctrl #(
    parameter int DEPTH      = 8,
    parameter int PC_W       = 32,
    parameter int RESET_TIER = 0,
    parameter int MAX_TIER   = 6,
    localparam int SP_W      = $clog2(DEPTH + 1),
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    carbon_mode_stack_if.slave   bus,
    input  logic [7:0]           tier_ceiling,
    output logic [7:0]           tier_q,
    output logic [SP_W-1:0]      sp_q,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RESP} state_t;
    state_t state, state_nx;
    logic            op_r;
    logic [7:0]      tier_r;
    logic [PC_W-1:0] pc_r;
    logic [31:0]     cause_r, cause_c;
    logic [7:0]      limit;
    logic [7+PC_W:0] stack [DEPTH];
    logic [7+PC_W:0] top;
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.req_valid ? CHECK : IDLE;
            CHECK:   state_nx = COMMIT;
            COMMIT:  state_nx = RESP;
            default: state_nx = bus.rsp_ready ? IDLE : RESP;
        endcase
    end
    always_comb begin
        bus.req_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        busy          = state != IDLE;
    end
    // Trap priority: overflow beats invalid target; underflow only applies to RETMD
    always_comb begin
        limit   = (tier_ceiling < 8'(MAX_TIER)) ? tier_ceiling : 8'(MAX_TIER);
        cause_c = !op_r ? ((sp_q == SP_W'(DEPTH)) ? 32'h13 :
                           (tier_r <= tier_q || tier_r > limit) ? 32'h12 : 32'h0)
                        : ((sp_q == '0) ? 32'h14 : 32'h0);
        top     = stack[IDX_W'(sp_q - SP_W'(1))];
    end
    always_ff @(posedge clk)
        if (state == COMMIT && cause_r == '0 && !op_r)
            stack[IDX_W'(sp_q)] <= {tier_q, pc_r};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tier_q        <= 8'(RESET_TIER);
            sp_q          <= '0;
            op_r          <= 1'b0;
            tier_r        <= '0;
            pc_r          <= '0;
            cause_r       <= '0;
            bus.rsp_ok    <= 1'b0;
            bus.rsp_tier  <= '0;
            bus.rsp_pc    <= '0;
            bus.rsp_cause <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_r   <= bus.req_op;
                    tier_r <= bus.req_tier;
                    pc_r   <= bus.req_pc;
                end
                CHECK: cause_r <= cause_c;
                COMMIT: begin
                    bus.rsp_ok    <= cause_r == '0;
                    bus.rsp_cause <= cause_r;
                    bus.rsp_tier  <= tier_q;
                    bus.rsp_pc    <= pc_r;
                    if (cause_r == '0 && !op_r) begin
                        sp_q         <= sp_q + SP_W'(1);
                        tier_q       <= tier_r;
                        bus.rsp_tier <= tier_r;
                    end else if (cause_r == '0) begin
                        sp_q         <= sp_q - SP_W'(1);
                        tier_q       <= top[7+PC_W:PC_W];
                        bus.rsp_tier <= top[7+PC_W:PC_W];
                        bus.rsp_pc   <= top[PC_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
